// File: rtl/chan_550_avgiq_capture.sv
// Averaged I/Q time-series capture for one channel into a 64-bit capture BRAM.
// Optional AVGIQ_TIMESTAMP_EN adds bram_ts: the sync-event count at each write.
module chan_550_avgiq_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int CHAN_BITS  = 9,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                         user_clk,
  input  logic                         user_rst,
  input  logic [31:0]                  ctrl_word,
  input  logic                         sync_in,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] i_in,
  input  logic signed [DATA_WIDTH-1:0] q_in,
  output logic                         bram_we,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  output logic [63:0]                  bram_data,
  output logic                         busy,
  output logic                         done
`ifdef AVGIQ_TIMESTAMP_EN
  ,
  output logic [31:0]                  bram_ts
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACCUM,
    FIN
  } state_t;

  state_t state, state_d;

  logic                  start_q;
  logic [8:0]            chan_sel_q;
  logic [3:0]            log2_navg_q;
  logic [CHAN_BITS-1:0]  ch_cnt, idx;
  logic [31:0]           acc_i, acc_q;
  logic [31:0]           sum_i, sum_q;
  logic [15:0]           avg_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  start_edge, match, last;
  logic                  take, wr, clr, arm;
  logic                  unused_ctrl;

  assign unused_ctrl = ^{ctrl_word[30:13]};

  assign start_edge = ctrl_word[31] && !start_q;
  assign idx        = sync_in ? '0 : ch_cnt;
  assign match      = din_valid && (32'(idx) == 32'(chan_sel_q));
  assign sum_i      = acc_i + 32'(i_in);
  assign sum_q      = acc_q + 32'(q_in);
  assign last       = avg_cnt == ((16'd1 << log2_navg_q) - 16'd1);

  always_comb begin
    state_d = state;
    take    = 1'b0;
    clr     = 1'b0;
    arm     = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (start_edge) begin
          arm     = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        // the sync sample that arms the capture is itself a frame-0 sample
        if (din_valid && sync_in) begin
          take    = match;
          state_d = ACCUM;
        end
      end
      ACCUM: take = match;
      FIN: begin
        if (start_edge) begin
          arm     = 1'b1;
          clr     = 1'b1;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
    wr = take && last;
    if (wr && (wr_addr == '1)) state_d = FIN;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= IDLE;
    else          state <= state_d;
  end

  // start_q follows the pin through reset so a held start is not an edge
  always_ff @(posedge user_clk) begin
    start_q <= ctrl_word[31];
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      chan_sel_q  <= '0;
      log2_navg_q <= '0;
    end else if (arm) begin
      chan_sel_q  <= ctrl_word[8:0];
      log2_navg_q <= ctrl_word[12:9];
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ch_cnt    <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      avg_cnt   <= '0;
      wr_addr   <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (din_valid) ch_cnt <= idx + CHAN_BITS'(1);
      bram_we <= wr;
      busy    <= (state_d == ARM) || (state_d == ACCUM);
      done    <= state_d == FIN;
      if (clr) begin
        acc_i   <= '0;
        acc_q   <= '0;
        avg_cnt <= '0;
        wr_addr <= '0;
      end else if (wr) begin
        acc_i     <= '0;
        acc_q     <= '0;
        avg_cnt   <= '0;
        wr_addr   <= wr_addr + ADDR_WIDTH'(1);
        bram_addr <= wr_addr;
        bram_data <= {sum_i, sum_q};
      end else if (take) begin
        acc_i   <= sum_i;
        acc_q   <= sum_q;
        avg_cnt <= avg_cnt + 16'd1;
      end
    end
  end

`ifdef AVGIQ_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_next;

  assign ts_next = ts_cnt + 32'(sync_in && din_valid);

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ts_cnt  <= '0;
      bram_ts <= '0;
    end else begin
      ts_cnt <= ts_next;
      if (wr) bram_ts <= ts_next;
    end
  end
`endif

endmodule

// File: tb/tb_chan_550_avgiq_capture.sv
// Randomized bench for chan_550_avgiq_capture with a point-level reference model.
// Build with AVGIQ_TIMESTAMP_EN to also check bram_ts.
module tb_chan_550_avgiq_capture;

  localparam int DW   = 16;
  localparam int CB   = 3;
  localparam int AW   = 2;
  localparam int NCH  = 8;
  localparam int NPTS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ctrl_word;
  logic          sync_in, din_valid;
  logic signed [DW-1:0] i_in, q_in;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [63:0]   bram_data;
  logic          busy, done;
  logic [31:0]   bram_ts;

  always #5 clk = ~clk;

  chan_550_avgiq_capture #(
    .DATA_WIDTH(DW),
    .CHAN_BITS (CB),
    .ADDR_WIDTH(AW)
  ) dut (
    .user_clk (clk),
    .user_rst (rst),
    .ctrl_word(ctrl_word),
    .sync_in  (sync_in),
    .din_valid(din_valid),
    .i_in     (i_in),
    .q_in     (q_in),
    .bram_we  (bram_we),
    .bram_addr(bram_addr),
    .bram_data(bram_data),
    .busy     (busy),
    .done     (done)
`ifdef AVGIQ_TIMESTAMP_EN
    ,
    .bram_ts  (bram_ts)
`endif
  );

`ifndef AVGIQ_TIMESTAMP_EN
  assign bram_ts = '0;
`endif

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
    logic [63:0] data;
    logic [31:0] ts;
  } wr_t;

  typedef struct {
    int cyc;
    int i;
    int q;
    int ts;
  } smp_t;

  wr_t  wq[$];
  smp_t sq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_sync = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bram_we) wq.push_back('{cyc, bram_addr, bram_data, bram_ts});

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit s, bit v, logic [DW-1:0] i, logic [DW-1:0] q);
    sync_in   = s;
    din_valid = v;
    i_in      = i;
    q_in      = q;
    if (s && v) n_sync++;
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, DW'($urandom), DW'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync_in = 1'b0;
    din_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_sync = 0;
  endtask

  // mode 0: random data, 1: constant 100/-3, 2: I ramps with frame number
  task automatic run(int sel, int navg, bit gaps, int mode, bit disturb);
    int nn;
    int frames;
    logic signed [DW-1:0] ri, rq;
    nn = 1 << navg;
    frames = NPTS * nn + 1;
    sq.delete();
    wq.delete();
    idle(2);
    ctrl_word = 32'h8000_0000 | (32'(navg) << 9) | 32'(sel);
    idle(1);
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    ctrl_word[31] = 1'b0;
    idle($urandom_range(0, 3));
    for (int f = 0; f < frames; f++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (gaps)
          repeat ($urandom_range(0, 3))
            drive(1'($urandom), 1'b0, DW'($urandom), DW'($urandom));
        if (disturb && f == 1 && ch == 2)
          ctrl_word = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 9)
                    | 32'((sel + 1) % NCH);
        if (disturb && f == 1 && ch == 5) ctrl_word[31] = 1'b0;
        case (mode)
          1: begin ri = 100; rq = -3; end
          2: begin ri = DW'(f + 1); rq = DW'($urandom); end
          default: begin ri = DW'($urandom); rq = DW'($urandom); end
        endcase
        if (ch == sel && sq.size() < NPTS * nn)
          sq.push_back('{cyc, int'(ri), int'(rq), n_sync + (ch == 0 ? 1 : 0)});
        drive(ch == 0, 1'b1, ri, rq);
      end
    end
    idle(2);
    check("n_writes", 64'(wq.size()), NPTS);
    for (int k = 0; k < NPTS && k < wq.size(); k++) begin
      int si, sqs;
      si = 0;
      sqs = 0;
      for (int j = 0; j < nn; j++) begin
        si  += sq[k * nn + j].i;
        sqs += sq[k * nn + j].q;
      end
      check("addr", 64'(wq[k].addr), 64'(k));
      check("data", wq[k].data, {32'(si), 32'(sqs)});
      check("latency", 64'(wq[k].cyc), 64'(sq[k * nn + nn - 1].cyc + 1));
`ifdef AVGIQ_TIMESTAMP_EN
      check("ts", 64'(wq[k].ts), 64'(sq[k * nn + nn - 1].ts));
`endif
    end
    if (mode == 1 && wq.size() > 0)
      check("const_point", wq[0].data, 64'h00000190_FFFFFFF4);
    if (mode == 2 && navg == 0 && wq.size() == NPTS)
      for (int k = 0; k < NPTS; k++)
        check("ramp_i", 64'(wq[k].data[63:32]), 64'(k + 1));
    check("done_end", done, 1);
    check("busy_end", busy, 0);
  endtask

  initial begin
    ctrl_word = '0;
    sync_in   = 1'b0;
    din_valid = 1'b0;
    i_in      = '0;
    q_in      = '0;
    do_reset();
    check("rst_we", bram_we, 0);
    check("rst_addr", 64'(bram_addr), 0);
    check("rst_data", bram_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    run(5, 2, 1'b0, 1, 1'b0);
    run(0, 0, 1'b0, 2, 1'b0);
    run(3, 1, 1'b0, 0, 1'b1);

    // reset after two points of a capture
    wq.delete();
    ctrl_word = 32'h8000_0000 | 32'd5;
    idle(1);
    ctrl_word = 32'd5;
    for (int f = 0; f < 2; f++)
      for (int ch = 0; ch < NCH; ch++)
        drive(ch == 0, 1'b1, DW'($urandom | 1), DW'($urandom));
    idle(1);
    check("abort_writes", 64'(wq.size()), 2);
    rst = 1'b1;
    step();
    check("abort_we", bram_we, 0);
    check("abort_addr", 64'(bram_addr), 0);
    check("abort_data", bram_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);

    // start held high across reset release is not an edge
    ctrl_word = 32'h8000_0000;
    step();
    rst = 1'b0;
    n_sync = 0;
    idle(3);
    check("held_start_busy", busy, 0);
    ctrl_word = '0;

    run(5, 0, 1'b0, 0, 1'b0);
    for (int r = 0; r < 6; r++)
      run($urandom_range(0, NCH - 1), $urandom_range(0, 2), 1'b1, 0,
          1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chan_550_avgiq_capture.md
# chan_550_avgiq_capture

Consumer of the 32-bit avgIQ control word in the `user_clk` domain. Captures a time series of averaged I/Q for one software-selected channel of the channelizer stream:
- sums `2^log2_navg` consecutive frames of that channel;
- writes each sum as one 64-bit word into a capture BRAM at an incrementing address;
- stops and flags done once the BRAM is full.

## Interface
Parameters:
- `DATA_WIDTH`, 16: signed width of `i_in` and `q_in`.
- `CHAN_BITS`, 9: channel index width; number of channels is `2^CHAN_BITS`.
- `ADDR_WIDTH`, 9: capture BRAM address width; depth is `2^ADDR_WIDTH` points.

Ports:
- `user_clk`  in  1: single clock for the whole block.
- `user_rst`  in  1: synchronous, active-high reset.
- `ctrl_word`  in  32: control word, already in the `user_clk` domain.
  - [31] `start`
  - [12:9] `log2_navg`
  - [8:0] `chan_sel`
  - all other bits reserved and ignored.
- `sync_in`  in  1: frame marker. Qualified by `din_valid`; the marked sample is channel 0.
- `din_valid`  in  1: one channel sample presented this cycle.
- `i_in`, `q_in`  in  `DATA_WIDTH` each: signed I and Q samples.
- `bram_we`  out  1: BRAM write strobe, one cycle per point.
- `bram_addr`  out  `ADDR_WIDTH`: write address.
- `bram_data`  out  64: {I_sum[31:0], Q_sum[31:0]}, two's complement.
- `busy`  out  1: capture in progress (states ARM or ACCUM).
- `done`  out  1: capture complete; BRAM contents valid.

## Operation
**Channel counter `ch_cnt`**
- `idx = sync_in ? 0 : ch_cnt`.
- On `din_valid`: `ch_cnt <= idx + 1`, wrapping modulo `2^CHAN_BITS`.
- A sample "matches" when `din_valid && idx == chan_sel_q`.

**Start edge**
- `start` is registered each cycle. Rising edge = `start && !start_q`.
- On the edge, latch `chan_sel_q` and `log2_navg_q`. Later changes to `ctrl_word` have no effect until the next edge.

**FSM states**
- IDLE:
  - start edge → ARM.
  - Clears `done`, `wr_addr` and the accumulators.
- ARM: `busy=1`.
  - On `din_valid && sync_in` → ACCUM.
  - That same sample is processed as a frame-0 sample, so it counts if `chan_sel_q == 0`.
- ACCUM: `busy=1`.
  - On a match: `acc_i += sext32(i_in)`, `acc_q += sext32(q_in)`, `avg_cnt += 1`.
  - On the match where `avg_cnt == 2^log2_navg_q - 1`:
    - register `bram_data = {acc_i + sext(i_in), acc_q + sext(q_in)}`, `bram_addr = wr_addr`, `bram_we = 1`;
    - zero `acc_i`, `acc_q` and `avg_cnt`;
    - increment `wr_addr`.
  - If that write used `wr_addr == 2^ADDR_WIDTH - 1` → DONE.
- DONE: `done=1`, `busy=0`.
  - Start edge → ARM; clears `done`, `wr_addr` and the accumulators in the same cycle.

**Width and arithmetic rules**
- Maximum sum magnitude is `2^15 * 2^(DATA_WIDTH-1)`, which fits in 32 bits. No saturation is required.
- Sums are raw; software divides by `2^log2_navg`.
- `log2_navg = 0` means every match is written directly (sum of one sample).

**Boundary conditions**
- Start edge in ARM or ACCUM: ignored; the capture continues.
- `sync_in` during ACCUM: only realigns `ch_cnt`; the FSM is unaffected.
- `sync_in` without `din_valid`: ignored.
- `start` already high at reset release: not an edge; the block stays in IDLE.

## Timing
- Reset values: `bram_we=0`, `bram_addr=0`, `bram_data=0`, `busy=0`, `done=0`, state IDLE, `ch_cnt=0`.
- Reset mid-capture returns to IDLE on the next edge. No partial point is written.
- Start edge seen in cycle n → `busy=1` in cycle n+1.
- Last contributing sample in cycle n → `bram_we=1` for exactly cycle n+1, with `bram_addr` and `bram_data` valid in that cycle.
- Final write in cycle n+1 → `done=1` and `busy=0` from cycle n+1 onward.
- All outputs are registered.

## Configuration
- `AVGIQ_TIMESTAMP_EN` defined:
  - adds output port `bram_ts [31:0]`;
  - a free-running counter of `sync_in && din_valid` events is cleared only by `user_rst` and wraps at 2^32;
  - `bram_ts` is registered alongside `bram_data` on each write.
- Not defined: no port and no counter logic.

## Test plan
- ADDR_WIDTH=2, `chan_sel=5`, `log2_navg=2`, `CHAN_BITS=3`, continuous valid, constant I=100 and Q=-3 → 4 writes at addr 0..3, each with `bram_data=64'h00000190_FFFFFFF4`; then `done=1`, `busy=0`.
- `log2_navg=0`, `chan_sel=0`, I ramps 1,2,3,4 on successive frames → data I fields 1,2,3,4, each `bram_we` exactly one cycle after the matching sample.
- `chan_sel` changed mid-capture and a second start pulse issued while busy → results unchanged and no restart.
- `user_rst` asserted after 2 writes → all outputs 0 next cycle; a new start edge → writes begin again at addr 0.
- `din_valid` gaps of 0–3 cycles and a sync arriving with `din_valid=0` → sums identical to the gap-free run.
- With `AVGIQ_TIMESTAMP_EN`: 3 syncs before start, `log2_navg=1`, `chan_sel=0` → first write carries `bram_ts=5`, second carries 7.
